// File: rtl/invader_fleet_pkg.sv
// Formation geometry shared between the invader state block and the renderer.
package invader_fleet_pkg;
  localparam int INVADERS_H  = 11;
  localparam int INVADERS_V  = 5;
  localparam int BITMAP_W    = INVADERS_H * INVADERS_V;
  localparam int OFFSET_H    = 32;
  localparam int OFFSET_V    = 24;
  localparam int START_X     = 64;
  localparam int START_Y     = 48;
  localparam int STEP_H      = 4;
  localparam int STEP_V      = 16;
  localparam int SCREEN_W    = 640;
  localparam int BOTTOM_Y    = 432;
  localparam int STEP_FRAMES = 8;
endpackage

// File: rtl/invader_fleet_edge_scan.sv
// Combinational occupancy scan: leftmost/rightmost live column, lowest live row.
module fleet_edge_scan
  import invader_fleet_pkg::*;
(
  input  logic [BITMAP_W-1:0] bitmap,
  output logic [3:0]          lc,
  output logic [3:0]          rc,
  output logic [2:0]          br,
  output logic                any
);
  logic [INVADERS_H-1:0] col_occ;
  logic [INVADERS_V-1:0] row_occ;

  always_comb begin
    col_occ = '0;
    row_occ = '0;
    for (int r = 0; r < INVADERS_V; r++) begin
      for (int c = 0; c < INVADERS_H; c++) begin
        if (bitmap[r*INVADERS_H + c]) begin
          col_occ[c] = 1'b1;
          row_occ[r] = 1'b1;
        end
      end
    end
    lc = '0;
    rc = '0;
    br = '0;
    // Scanning downward for lc and upward for rc/br lets the last hit win.
    for (int c = INVADERS_H-1; c >= 0; c--) if (col_occ[c]) lc = 4'(c);
    for (int c = 0; c < INVADERS_H; c++)    if (col_occ[c]) rc = 4'(c);
    for (int r = 0; r < INVADERS_V; r++)    if (row_occ[r]) br = 3'(r);
    any = |bitmap;
  end
endmodule

// File: rtl/invader_fleet.sv
// Invader formation state: alive bitmap, origin, marching and hit removal.
// Define INVADER_FLEET_SPEEDUP_EN to tie the step period to the alive count.
module invader_fleet
  import invader_fleet_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                frame,
  input  logic                start,
  input  logic                hit_valid,
  input  logic [5:0]          hit_index,
  output logic [BITMAP_W-1:0] invaders,
  output logic [9:0]          invaders_x,
  output logic [9:0]          invaders_y,
  output logic [5:0]          alive_count,
  output logic                wave_clear,
  output logic                reached_bottom
);
  typedef enum logic [1:0] {IDLE, ACTIVE, CLEARED, LANDED} state_t;

  state_t              state;
  logic                dir_left;
  logic [4:0]          cnt;
  logic [4:0]          period;
  logic [3:0]          lc, rc;
  logic [2:0]          br;
  logic                any_alive;
  logic [10:0]         x_w, y_w, right_edge, left_edge, y_step, land_edge;
  logic [9:0]          x_step;
  logic                step_due, descend, landing, hit_ok;
  logic [63:0]         hit_space;
  logic [BITMAP_W-1:0] hit_mask;

  fleet_edge_scan u_scan (
    .bitmap (invaders),
    .lc     (lc),
    .rc     (rc),
    .br     (br),
    .any    (any_alive)
  );

  function automatic logic [10:0] sat_sub(input logic [10:0] a, input logic [10:0] b);
    return (a < b) ? 11'd0 : a - b;
  endfunction

  always_comb begin
`ifdef INVADER_FLEET_SPEEDUP_EN
    period = 5'd1 + {1'b0, alive_count[5:2], alive_count[1]};
`else
    period = 5'(STEP_FRAMES);
`endif
    x_w        = {1'b0, invaders_x};
    y_w        = {1'b0, invaders_y};
    right_edge = x_w + 11'(OFFSET_H) * (11'(rc) + 11'd1);
    left_edge  = x_w + 11'(OFFSET_H) * 11'(lc);
    descend    = dir_left ? (left_edge < 11'(STEP_H))
                          : (right_edge + 11'(STEP_H) > 11'(SCREEN_W));
    y_step     = descend ? y_w + 11'(STEP_V) : y_w;
    x_step     = descend  ? invaders_x :
                 dir_left ? 10'(sat_sub(x_w, 11'(STEP_H))) : 10'(x_w + 11'(STEP_H));
    land_edge  = y_step + 11'(OFFSET_V) * (11'(br) + 11'd1);
    // >= rather than == so a shrinking period fires immediately.
    step_due   = frame && any_alive && (cnt >= period - 5'd1);
    landing    = step_due && descend && (land_edge >= 11'(BOTTOM_Y));
    hit_space  = 64'(invaders);
    hit_ok     = hit_valid && (hit_index < 6'(BITMAP_W)) && hit_space[hit_index];
    hit_mask   = hit_ok ? (BITMAP_W'(1) << hit_index) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      invaders       <= '0;
      invaders_x     <= 10'(START_X);
      invaders_y     <= 10'(START_Y);
      alive_count    <= '0;
      dir_left       <= 1'b0;
      cnt            <= '0;
      wave_clear     <= 1'b0;
      reached_bottom <= 1'b0;
    end else if (start) begin
      state          <= ACTIVE;
      invaders       <= '1;
      invaders_x     <= 10'(START_X);
      invaders_y     <= 10'(START_Y);
      alive_count    <= 6'(BITMAP_W);
      dir_left       <= 1'b0;
      cnt            <= '0;
      wave_clear     <= 1'b0;
      reached_bottom <= 1'b0;
    end else if (state == ACTIVE) begin
      if (frame) begin
        if (step_due) begin
          cnt        <= '0;
          invaders_x <= x_step;
          invaders_y <= y_step[9:0];
          if (descend) dir_left <= ~dir_left;
        end else begin
          cnt <= cnt + 5'd1;
        end
      end
      if (hit_ok) begin
        invaders    <= invaders & ~hit_mask;
        alive_count <= alive_count - 6'd1;
      end
      if (hit_ok && alive_count == 6'd1) begin
        state      <= CLEARED;
        wave_clear <= 1'b1;
      end else if (landing) begin
        state          <= LANDED;
        reached_bottom <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_invader_fleet.sv
// Directed bench for invader_fleet in the fixed-speed build (8 frames per step).
module tb_invader_fleet;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame = 1'b0;
  logic        start = 1'b0;
  logic        hit_valid = 1'b0;
  logic [5:0]  hit_index = '0;
  logic [54:0] invaders;
  logic [9:0]  invaders_x, invaders_y;
  logic [5:0]  alive_count;
  logic        wave_clear, reached_bottom;

  int n_tests = 0;
  int n_fail  = 0;
  logic [54:0] exp_bm;

  invader_fleet dut (
    .clk            (clk),
    .rst            (rst),
    .frame          (frame),
    .start          (start),
    .hit_valid      (hit_valid),
    .hit_index      (hit_index),
    .invaders       (invaders),
    .invaders_x     (invaders_x),
    .invaders_y     (invaders_y),
    .alive_count    (alive_count),
    .wave_clear     (wave_clear),
    .reached_bottom (reached_bottom)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_frame();
    frame = 1'b1;
    tick();
    frame = 1'b0;
    tick();
  endtask

  task automatic do_steps(input int n);
    for (int i = 0; i < n; i++) repeat (8) pulse_frame();
  endtask

  task automatic do_hit(input int idx);
    hit_valid = 1'b1;
    hit_index = 6'(idx);
    tick();
    hit_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    exp_bm = '1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_invaders", 64'(invaders), 64'd0);
    chk("rst_x", 64'(invaders_x), 64'd64);
    chk("rst_y", 64'(invaders_y), 64'd48);
    chk("rst_alive", 64'(alive_count), 64'd0);
    chk("rst_flags", {62'd0, wave_clear, reached_bottom}, 64'd0);
    do_hit(0);
    pulse_frame();
    chk("idle_hit_ignored", 64'(alive_count), 64'd0);

    do_start();
    chk("start_invaders", 64'(invaders), 64'(exp_bm));
    chk("start_alive", 64'(alive_count), 64'd55);
    chk("start_xy", {44'd0, invaders_x, invaders_y}, {44'd0, 10'd64, 10'd48});
    chk("start_flags", {62'd0, wave_clear, reached_bottom}, 64'd0);

    repeat (7) pulse_frame();
    chk("seven_frames_x", 64'(invaders_x), 64'd64);
    frame = 1'b1;
    tick();
    frame = 1'b0;
    chk("eighth_frame_x", 64'(invaders_x), 64'd68);
    tick();

    do_steps(55);
    chk("march_x288", {44'd0, invaders_x, invaders_y}, {44'd0, 10'd288, 10'd48});
    do_steps(1);
    chk("right_descend", {44'd0, invaders_x, invaders_y}, {44'd0, 10'd288, 10'd64});
    do_steps(1);
    chk("march_left", {44'd0, invaders_x, invaders_y}, {44'd0, 10'd284, 10'd64});

    do_hit(10);
    exp_bm[10] = 1'b0;
    chk("hit10_bitmap", 64'(invaders), 64'(exp_bm));
    chk("hit10_alive", 64'(alive_count), 64'd54);
    do_hit(10);
    chk("hit10_dup", 64'(alive_count), 64'd54);
    do_hit(60);
    chk("hit60_alive", 64'(alive_count), 64'd54);
    chk("hit60_bitmap", 64'(invaders), 64'(exp_bm));

    // Fresh wave with the rightmost column removed.
    do_start();
    exp_bm = '1;
    do_hit(10); do_hit(21); do_hit(32); do_hit(43); do_hit(54);
    exp_bm[10] = 1'b0; exp_bm[21] = 1'b0; exp_bm[32] = 1'b0;
    exp_bm[43] = 1'b0; exp_bm[54] = 1'b0;
    chk("col10_bitmap", 64'(invaders), 64'(exp_bm));
    chk("col10_alive", 64'(alive_count), 64'd50);
    do_steps(57);
    chk("col10_past288", {44'd0, invaders_x, invaders_y}, {44'd0, 10'd292, 10'd48});
    do_steps(7);
    chk("col10_x320", {44'd0, invaders_x, invaders_y}, {44'd0, 10'd320, 10'd48});
    do_steps(1);
    chk("col10_descend", {44'd0, invaders_x, invaders_y}, {44'd0, 10'd320, 10'd64});

    for (int i = 0; i <= 52; i++) do_hit(i);
    chk("one_left_alive", 64'(alive_count), 64'd1);
    chk("one_left_clear", 64'(wave_clear), 64'd0);
    do_hit(53);
    chk("cleared_alive", 64'(alive_count), 64'd0);
    chk("cleared_bitmap", 64'(invaders), 64'd0);
    chk("cleared_flag", 64'(wave_clear), 64'd1);
    repeat (16) pulse_frame();
    chk("cleared_frozen", {44'd0, invaders_x, invaders_y}, {44'd0, 10'd320, 10'd64});

    // Full formation marches down: descend k lands y at 48+16k.
    do_start();
    chk("restart_flags", {62'd0, wave_clear, reached_bottom}, 64'd0);
    do_steps(1224);
    chk("pre_land_xy", {44'd0, invaders_x, invaders_y}, {44'd0, 10'd288, 10'd304});
    chk("pre_land_flag", 64'(reached_bottom), 64'd0);
    do_steps(1);
    chk("land_xy", {44'd0, invaders_x, invaders_y}, {44'd0, 10'd288, 10'd320});
    chk("land_flag", {62'd0, wave_clear, reached_bottom}, 64'd1);
    do_hit(0);
    repeat (16) pulse_frame();
    chk("landed_frozen", {44'd0, invaders_x, invaders_y}, {44'd0, 10'd288, 10'd320});
    chk("landed_hit_ignored", 64'(alive_count), 64'd55);

    do_start();
    chk("reload_flags", {62'd0, wave_clear, reached_bottom}, 64'd0);
    chk("reload_xy", {44'd0, invaders_x, invaders_y}, {44'd0, 10'd64, 10'd48});
    do_steps(1);
    chk("reload_active", 64'(invaders_x), 64'd68);

    do_hit(5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midwave_rst_bitmap", 64'(invaders), 64'd0);
    chk("midwave_rst_xy", {44'd0, invaders_x, invaders_y}, {44'd0, 10'd64, 10'd48});
    chk("midwave_rst_alive", 64'(alive_count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
